// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - shared types and helpers for the quadrature encoder front end
//
// Purpose: phase type, FSM state encoding, error-counter width and the Gray-code
//          neighbour functions used by quadrature_frontend.
// Contents:
//   phase_t      2-bit {a,b} phase
//   state_t      INIT (startup settle) / TRACK (decode)
//   ERR_CNT_W    width of the saturating illegal-transition counter
//   next_phase() forward neighbour in 00 -> 01 -> 11 -> 10 -> 00
//   prev_phase() reverse neighbour in the same sequence
package quad_pkg;

    typedef logic [1:0] phase_t;

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam int ERR_CNT_W = 8;

    function automatic phase_t next_phase(input phase_t p);
        phase_t r;
        r = 2'b00;
        case (p)
            2'b00: r = 2'b01;
            2'b01: r = 2'b11;
            2'b11: r = 2'b10;
            2'b10: r = 2'b00;
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    function automatic phase_t prev_phase(input phase_t p);
        phase_t r;
        r = 2'b00;
        case (p)
            2'b00: r = 2'b10;
            2'b10: r = 2'b11;
            2'b11: r = 2'b01;
            2'b01: r = 2'b00;
            default: r = 2'b00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/quad_pin_filter.sv
// rtl/quad_pin_filter.sv - synchroniser and glitch filter for one encoder pin
//
// Purpose: brings an asynchronous pin into the clk domain through SYNC_STAGES
//          flops, then only accepts a new level once it has differed from the
//          accepted level for 2^FILTER_WIDTH consecutive cycles.
// Ports:
//   clk     in  system clock
//   rst     in  synchronous reset, active-high
//   bypass  in  1 = filtered output follows the synchronised input directly
//   in      in  raw asynchronous pin
//   out     out accepted (filtered) pin level
module quad_pin_filter #(
    parameter int SYNC_STAGES  = 2,
    parameter int FILTER_WIDTH = 11
) (
    input  logic clk,
    input  logic rst,
    input  logic bypass,
    input  logic in,
    output logic out
);
    import quad_pkg::*;

    localparam logic [FILTER_WIDTH-1:0] CNT_ONE = FILTER_WIDTH'(1);

    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic [FILTER_WIDTH-1:0] cnt_q, cnt_d;
    logic                    filt_q, filt_d;
    logic                    synced;

    assign synced = sync_q[SYNC_STAGES-1];
    assign out    = filt_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in};
        cnt_d  = '0;
        filt_d = filt_q;
        if (bypass) begin
            filt_d = synced;
        end else if (synced != filt_q) begin
            // Accept on the edge where the counter is already saturated, so the
            // new level has been seen on 2^FILTER_WIDTH consecutive edges.
            if (&cnt_q) begin
                filt_d = synced;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

endmodule

// File: rtl/quadrature_frontend.sv
// rtl/quadrature_frontend.sv - rotary encoder input conditioner and phase tracker
//
// Purpose: filters raw A/B pins, tracks the Gray-code phase and emits one-cycle
//          step/dir pulses; double-bit jumps raise err and bump a saturating count.
// Optional feature: QUAD_DETENT_DIVIDE_EN - when defined, legal transitions feed a
//          signed sub-step accumulator and step fires once per STEPS_PER_DETENT.
// Ports:
//   clk      in  system clock
//   rst      in  synchronous reset, active-high
//   a, b     in  raw encoder pins (asynchronous)
//   err_clr  in  one-cycle strobe clearing err_cnt
//   step     out one-cycle pulse per decoded step
//   dir      out direction of last step (1 = forward), held between steps
//   err      out one-cycle pulse on an illegal transition
//   err_cnt  out saturating illegal-transition count
//   phase    out current accepted {a,b} phase
module quadrature_frontend #(
    parameter int SYNC_STAGES      = 2,
    parameter int FILTER_WIDTH     = 11,
    parameter int STEPS_PER_DETENT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    input  logic       err_clr,
    output logic       step,
    output logic       dir,
    output logic       err,
    output logic [7:0] err_cnt,
    output logic [1:0] phase
);
    import quad_pkg::*;

    if (SYNC_STAGES < 2 || FILTER_WIDTH < 1 || STEPS_PER_DETENT < 2) begin : g_bad_param
        $error("quadrature_frontend: illegal parameter value");
    end

    localparam logic [FILTER_WIDTH-1:0] CNT_ONE = FILTER_WIDTH'(1);
    localparam logic [ERR_CNT_W-1:0]    ERR_ONE = ERR_CNT_W'(1);

    state_t                  state_q, state_d;
    logic [FILTER_WIDTH-1:0] start_cnt_q, start_cnt_d;
    phase_t                  phase_q, phase_d;
    logic                    dir_q, dir_d;
    logic                    step_q, step_d;
    logic                    err_q, err_d;
    logic [ERR_CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic                    a_filt, b_filt;
    phase_t                  filt_ab;
    logic                    bypass;

`ifdef QUAD_DETENT_DIVIDE_EN
    localparam int ACC_W = $clog2(STEPS_PER_DETENT) + 1;
    // The accumulator never holds +/-STEPS_PER_DETENT: the transition that
    // would reach it emits the step and returns to 0 instead.
    localparam logic signed [ACC_W-1:0] ACC_POS = ACC_W'(STEPS_PER_DETENT - 1);
    localparam logic signed [ACC_W-1:0] ACC_NEG = ACC_W'(1 - STEPS_PER_DETENT);
    localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);

    logic signed [ACC_W-1:0] acc_q, acc_d;
`endif

    assign bypass  = (state_q == INIT);
    assign filt_ab = {a_filt, b_filt};

    quad_pin_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_WIDTH(FILTER_WIDTH)
    ) u_filt_a (
        .clk   (clk),
        .rst   (rst),
        .bypass(bypass),
        .in    (a),
        .out   (a_filt)
    );

    quad_pin_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_WIDTH(FILTER_WIDTH)
    ) u_filt_b (
        .clk   (clk),
        .rst   (rst),
        .bypass(bypass),
        .in    (b),
        .out   (b_filt)
    );

    always_comb begin
        state_d     = state_q;
        start_cnt_d = start_cnt_q;
        phase_d     = phase_q;
        dir_d       = dir_q;
        step_d      = 1'b0;
        err_d       = 1'b0;
`ifdef QUAD_DETENT_DIVIDE_EN
        acc_d       = acc_q;
`endif

        // err_cnt follows the registered err pulse, so a clear strobe that
        // coincides with a visible err leaves a count of 1.
        err_cnt_d = err_clr ? '0 : err_cnt_q;
        if (err_q && (err_cnt_d != '1)) begin
            err_cnt_d = err_cnt_d + ERR_ONE;
        end

        case (state_q)
            INIT: begin
                if (&start_cnt_q) begin
                    phase_d = filt_ab;
                    state_d = TRACK;
                end else begin
                    start_cnt_d = start_cnt_q + CNT_ONE;
                end
            end
            TRACK: begin
                if (filt_ab == next_phase(phase_q)) begin
                    phase_d = filt_ab;
`ifdef QUAD_DETENT_DIVIDE_EN
                    if (acc_q == ACC_POS) begin
                        step_d = 1'b1;
                        dir_d  = 1'b1;
                        acc_d  = '0;
                    end else begin
                        acc_d = acc_q + ACC_ONE;
                    end
`else
                    step_d = 1'b1;
                    dir_d  = 1'b1;
`endif
                end else if (filt_ab == prev_phase(phase_q)) begin
                    phase_d = filt_ab;
`ifdef QUAD_DETENT_DIVIDE_EN
                    if (acc_q == ACC_NEG) begin
                        step_d = 1'b1;
                        dir_d  = 1'b0;
                        acc_d  = '0;
                    end else begin
                        acc_d = acc_q - ACC_ONE;
                    end
`else
                    step_d = 1'b1;
                    dir_d  = 1'b0;
`endif
                end else if (filt_ab != phase_q) begin
                    // Both bits moved at once: direction is unknowable.
                    phase_d = filt_ab;
                    err_d   = 1'b1;
`ifdef QUAD_DETENT_DIVIDE_EN
                    acc_d   = '0;
`endif
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT;
            start_cnt_q <= '0;
            phase_q     <= '0;
            dir_q       <= 1'b0;
            step_q      <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
`ifdef QUAD_DETENT_DIVIDE_EN
            acc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            start_cnt_q <= start_cnt_d;
            phase_q     <= phase_d;
            dir_q       <= dir_d;
            step_q      <= step_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
`ifdef QUAD_DETENT_DIVIDE_EN
            acc_q       <= acc_d;
`endif
        end
    end

    assign step    = step_q;
    assign dir     = dir_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;
    assign phase   = phase_q;

endmodule
